id_ex_pipeline_register: RTL and testbench
==========================================

Name: id_ex_pipeline_register

Overview:
ID/EX pipeline register for the RV32IM 5-stage core. It sits directly downstream of the WB forwarding control unit and the register file.
- Captures decoded operands, immediate, PC, destination and control bundle each cycle.
- Substitutes WB-stage write data for either operand when the matching forward enable is asserted.
- Supports stall (hold) and flush (bubble insert).
- While holding, it keeps snooping WB writes so held operands never go stale.

Parameters:
XLEN, 32, datapath width
CTRL_W, 16, width of packed control bundle (ALU op, mem r/w, wb select, reg write, branch/jump flags)
REGWRITE_BIT, 0, bit index of register-write enable inside the control bundle

Ports:
CLK  in  1  core clock, rising-edge
RESET_N  in  1  synchronous reset, active-low
STALL  in  1  hold current contents (hazard unit)
FLUSH  in  1  replace next contents with bubble (branch resolve / exception)
ID_VALID  in  1  ID stage holds a real instruction
ID_PC  in  XLEN  instruction PC
ID_DATA1  in  XLEN  register file read data, port 1
ID_DATA2  in  XLEN  register file read data, port 2
ID_IMM  in  XLEN  sign-extended immediate
ID_ADDR1  in  5  rs1 index
ID_ADDR2  in  5  rs2 index
ID_RD  in  5  destination index
ID_CTRL  in  CTRL_W  control bundle
OUT1_FORWARD_EN  in  1  from forwarding unit: use WB_DATA for operand 1
OUT2_FORWARD_EN  in  1  from forwarding unit: use WB_DATA for operand 2
WB_WRITE_EN  in  1  WB stage writing a register this cycle
WB_REGISTER  in  5  WB destination index
WB_DATA  in  XLEN  WB write data
EX_VALID  out  1  EX stage instruction valid
EX_PC  out  XLEN  registered PC
EX_DATA1  out  XLEN  registered operand 1
EX_DATA2  out  XLEN  registered operand 2
EX_IMM  out  XLEN  registered immediate
EX_ADDR1  out  5  registered rs1
EX_ADDR2  out  5  registered rs2
EX_RD  out  5  registered rd
EX_CTRL  out  CTRL_W  registered control bundle

Behaviour:
- All outputs are registered; latency is 1 cycle ID→EX. No combinational path from inputs to outputs.
- Reset: when RESET_N=0 at a rising edge, all outputs are cleared to 0 (EX_VALID=0, EX_CTRL=0, data/addr=0). Reset overrides FLUSH and STALL. Reset mid-stall discards the held instruction.
- Priority each edge: reset > FLUSH > STALL > load.
- Load (FLUSH=0, STALL=0):
  - EX_DATA1 <= OUT1_FORWARD_EN ? WB_DATA : ID_DATA1. EX_DATA2 is the same using OUT2_FORWARD_EN and ID_DATA2.
  - All other fields copied from ID_*.
  - EX_VALID <= ID_VALID.
  - If ID_VALID=0, EX_CTRL <= 0.
- Forward gating: a forward enable is ignored when the corresponding ID_ADDRx==0, so x0 always reads 0 from the register file value.
- FLUSH=1: EX_VALID<=0, EX_CTRL<=0, EX_RD<=0. Data fields hold their previous value (don't-care). FLUSH with STALL simultaneously produces a bubble.
- STALL=1 (no flush): all fields hold, except the WB snoop.
  - If WB_WRITE_EN=1, WB_REGISTER!=0 and WB_REGISTER==EX_ADDR1, then EX_DATA1<=WB_DATA.
  - Same for EX_ADDR2/EX_DATA2, independently.
  - Both operands update if both match.
- Snoop applies only while EX_VALID=1; a held bubble is not modified.
- Consecutive stalls: snoop is evaluated every stalled cycle, and the last matching write wins.
- Control bit REGWRITE_BIT is forced to 0 whenever EX_VALID is 0.

Optional Feature:
Macro: IDEX_BUBBLE_COUNT_EN.
- Defined: adds output BUBBLE_COUNT (32 bits, registered, reset to 0). It increments by 1 on each edge where a bubble is written, i.e. FLUSH=1, or a load with ID_VALID=0. It wraps at 2^32 to 0 and does not increment on stall-hold cycles.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package (pipeline_pkg) holds:
  - XLEN, CTRL_W and REGWRITE_BIT defaults
  - control-bundle bit-index constants
  - the bubble control value (all zeros)
  - the x0 index constant
- One natural sub-module, operand_latch: a single operand's select (forward / register file), hold and snoop logic. It is instantiated twice.

Test Plan:
- Reset: drive RESET_N=0 with STALL=1 and ID_VALID=1 → next edge, all outputs 0, including EX_VALID=0.
- Forward: ID_ADDR1=5, ID_DATA1=0x11, OUT1_FORWARD_EN=1, WB_DATA=0xABCD0001 → EX_DATA1=0xABCD0001. With ID_ADDR1=0 under the same stimulus → EX_DATA1=0x11.
- Stall snoop: load instruction with EX_ADDR2=7 and EX_DATA2=0x22. Then STALL=1 with WB_WRITE_EN=1, WB_REGISTER=7, WB_DATA=0x99 → EX_DATA2=0x99 and all other fields unchanged. With WB_REGISTER=0 → no change.
- Flush vs stall: FLUSH=1 and STALL=1 together → EX_VALID=0, EX_CTRL=0, EX_RD=0. Next cycle with both low → the new ID instruction is loaded.
- Back-to-back loads: five consecutive PCs 0x0,0x4,…,0x10 with no stalls → EX_PC follows exactly one cycle behind.
- IDEX_BUBBLE_COUNT_EN: 3 flush cycles and 2 invalid loads, interleaved with 4 stall cycles → BUBBLE_COUNT=5.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared constants and helpers for the ID/EX pipeline register of the RV32IM core.
// Optional feature macro used elsewhere in this slice: IDEX_BUBBLE_COUNT_EN.
package pipeline_pkg;

  localparam int DEF_XLEN         = 32;
  localparam int DEF_CTRL_W       = 16;
  localparam int DEF_REGWRITE_BIT = 0;

  // Control bundle layout: flags in the low bits, wb select, then ALU op.
  localparam int CTRL_REGWRITE   = 0;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_BRANCH     = 3;
  localparam int CTRL_JUMP       = 4;
  localparam int CTRL_WB_SEL_LSB = 5;
  localparam int CTRL_WB_SEL_W   = 2;
  localparam int CTRL_ALU_OP_LSB = 7;
  localparam int CTRL_ALU_OP_W   = 5;

  localparam logic [DEF_CTRL_W-1:0] CTRL_BUBBLE = '0;
  localparam logic [4:0]            REG_X0      = 5'd0;

  typedef enum logic [1:0] {
    ACT_RESET,
    ACT_FLUSH,
    ACT_HOLD,
    ACT_LOAD
  } stage_act_e;

  // Per-edge action: reset beats flush, flush beats stall, otherwise load.
  function automatic stage_act_e stage_action(input logic reset_n, input logic flush,
                                              input logic stall);
    if (!reset_n)   return ACT_RESET;
    else if (flush) return ACT_FLUSH;
    else if (stall) return ACT_HOLD;
    else            return ACT_LOAD;
  endfunction

endpackage

// File: rtl/id_ex_pipeline_register_if.sv
// ID-side inputs and EX-side outputs of the ID/EX register, grouped as one bus.
// BUBBLE_COUNT is present only when IDEX_BUBBLE_COUNT_EN is defined.
interface id_ex_pipeline_register_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16
);
  logic              STALL;
  logic              FLUSH;
  logic              ID_VALID;
  logic [XLEN-1:0]   ID_PC;
  logic [XLEN-1:0]   ID_DATA1;
  logic [XLEN-1:0]   ID_DATA2;
  logic [XLEN-1:0]   ID_IMM;
  logic [4:0]        ID_ADDR1;
  logic [4:0]        ID_ADDR2;
  logic [4:0]        ID_RD;
  logic [CTRL_W-1:0] ID_CTRL;
  logic              OUT1_FORWARD_EN;
  logic              OUT2_FORWARD_EN;
  logic              WB_WRITE_EN;
  logic [4:0]        WB_REGISTER;
  logic [XLEN-1:0]   WB_DATA;
  logic              EX_VALID;
  logic [XLEN-1:0]   EX_PC;
  logic [XLEN-1:0]   EX_DATA1;
  logic [XLEN-1:0]   EX_DATA2;
  logic [XLEN-1:0]   EX_IMM;
  logic [4:0]        EX_ADDR1;
  logic [4:0]        EX_ADDR2;
  logic [4:0]        EX_RD;
  logic [CTRL_W-1:0] EX_CTRL;
`ifdef IDEX_BUBBLE_COUNT_EN
  logic [31:0]       BUBBLE_COUNT;
`endif

  modport master (
    output STALL, FLUSH, ID_VALID, ID_PC, ID_DATA1, ID_DATA2, ID_IMM,
           ID_ADDR1, ID_ADDR2, ID_RD, ID_CTRL, OUT1_FORWARD_EN, OUT2_FORWARD_EN,
           WB_WRITE_EN, WB_REGISTER, WB_DATA,
`ifdef IDEX_BUBBLE_COUNT_EN
    input  BUBBLE_COUNT,
`endif
    input  EX_VALID, EX_PC, EX_DATA1, EX_DATA2, EX_IMM, EX_ADDR1, EX_ADDR2,
           EX_RD, EX_CTRL
  );

  modport slave (
    input  STALL, FLUSH, ID_VALID, ID_PC, ID_DATA1, ID_DATA2, ID_IMM,
           ID_ADDR1, ID_ADDR2, ID_RD, ID_CTRL, OUT1_FORWARD_EN, OUT2_FORWARD_EN,
           WB_WRITE_EN, WB_REGISTER, WB_DATA,
`ifdef IDEX_BUBBLE_COUNT_EN
    output BUBBLE_COUNT,
`endif
    output EX_VALID, EX_PC, EX_DATA1, EX_DATA2, EX_IMM, EX_ADDR1, EX_ADDR2,
           EX_RD, EX_CTRL
  );

endinterface

// File: rtl/id_ex_pipeline_register_operand_latch.sv
// One EX operand: forward/register-file select on load, hold on stall while
// still snooping WB writes to the held source register.
module operand_latch
  import pipeline_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic            clk,
  input  stage_act_e      act,
  input  logic [4:0]      id_addr,
  input  logic [XLEN-1:0] id_data,
  input  logic            fwd_en,
  input  logic            wb_write_en,
  input  logic [4:0]      wb_register,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_valid,
  output logic [4:0]      ex_addr,
  output logic [XLEN-1:0] ex_data
);

  logic [4:0]      addr_p1;
  logic [XLEN-1:0] data_p1;
  logic            use_fwd;
  logic            snoop_hit;

  // x0 never takes a forwarded value; a held bubble is never refreshed.
  assign use_fwd   = fwd_en && (id_addr != REG_X0);
  assign snoop_hit = ex_valid && wb_write_en && (wb_register != REG_X0) &&
                     (wb_register == addr_p1);

  // ID -> EX boundary
  always_ff @(posedge clk) begin
    case (act)
      ACT_RESET: begin
        addr_p1 <= '0;
        data_p1 <= '0;
      end
      ACT_HOLD: begin
        if (snoop_hit) data_p1 <= wb_data;
      end
      ACT_LOAD: begin
        addr_p1 <= id_addr;
        data_p1 <= use_fwd ? wb_data : id_data;
      end
      default: ;
    endcase
  end

  assign ex_addr = addr_p1;
  assign ex_data = data_p1;

endmodule

// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register with WB forwarding, stall/flush and stall-time WB snoop.
// Define IDEX_BUBBLE_COUNT_EN to add the registered BUBBLE_COUNT output.
module id_ex_pipeline_register
  import pipeline_pkg::*;
#(
  parameter int XLEN         = DEF_XLEN,
  parameter int CTRL_W       = DEF_CTRL_W,
  parameter int REGWRITE_BIT = DEF_REGWRITE_BIT
) (
  input logic                    CLK,
  input logic                    RESET_N,
  id_ex_pipeline_register_if.slave bus
);

  stage_act_e      act;
  logic            valid_p1;
  logic [XLEN-1:0] pc_p1;
  logic [XLEN-1:0] imm_p1;
  logic [4:0]      rd_p1;
  logic [CTRL_W-1:0] ctrl_p1;
  logic [CTRL_W-1:0] ctrl_load;

  assign act = stage_action(RESET_N, bus.FLUSH, bus.STALL);

  // An invalid ID slot enters EX as a bubble; register write is never left set on it.
  always_comb begin
    ctrl_load = bus.ID_VALID ? bus.ID_CTRL : CTRL_W'(CTRL_BUBBLE);
    ctrl_load[REGWRITE_BIT] = ctrl_load[REGWRITE_BIT] & bus.ID_VALID;
  end

  // ID -> EX boundary
  always_ff @(posedge CLK) begin
    case (act)
      ACT_RESET: begin
        valid_p1 <= 1'b0;
        pc_p1    <= '0;
        imm_p1   <= '0;
        rd_p1    <= '0;
        ctrl_p1  <= '0;
      end
      ACT_FLUSH: begin
        valid_p1 <= 1'b0;
        rd_p1    <= '0;
        ctrl_p1  <= CTRL_W'(CTRL_BUBBLE);
      end
      ACT_LOAD: begin
        valid_p1 <= bus.ID_VALID;
        pc_p1    <= bus.ID_PC;
        imm_p1   <= bus.ID_IMM;
        rd_p1    <= bus.ID_RD;
        ctrl_p1  <= ctrl_load;
      end
      default: ;
    endcase
  end

  operand_latch #(.XLEN(XLEN)) u_op1 (
    .clk         (CLK),
    .act         (act),
    .id_addr     (bus.ID_ADDR1),
    .id_data     (bus.ID_DATA1),
    .fwd_en      (bus.OUT1_FORWARD_EN),
    .wb_write_en (bus.WB_WRITE_EN),
    .wb_register (bus.WB_REGISTER),
    .wb_data     (bus.WB_DATA),
    .ex_valid    (valid_p1),
    .ex_addr     (bus.EX_ADDR1),
    .ex_data     (bus.EX_DATA1)
  );

  operand_latch #(.XLEN(XLEN)) u_op2 (
    .clk         (CLK),
    .act         (act),
    .id_addr     (bus.ID_ADDR2),
    .id_data     (bus.ID_DATA2),
    .fwd_en      (bus.OUT2_FORWARD_EN),
    .wb_write_en (bus.WB_WRITE_EN),
    .wb_register (bus.WB_REGISTER),
    .wb_data     (bus.WB_DATA),
    .ex_valid    (valid_p1),
    .ex_addr     (bus.EX_ADDR2),
    .ex_data     (bus.EX_DATA2)
  );

`ifdef IDEX_BUBBLE_COUNT_EN
  logic [31:0] bubble_cnt_p1;

  always_ff @(posedge CLK) begin
    if (act == ACT_RESET)
      bubble_cnt_p1 <= '0;
    else if ((act == ACT_FLUSH) || ((act == ACT_LOAD) && !bus.ID_VALID))
      bubble_cnt_p1 <= bubble_cnt_p1 + 32'd1;
  end

  assign bus.BUBBLE_COUNT = bubble_cnt_p1;
`endif

  assign bus.EX_VALID = valid_p1;
  assign bus.EX_PC    = pc_p1;
  assign bus.EX_IMM   = imm_p1;
  assign bus.EX_RD    = rd_p1;
  assign bus.EX_CTRL  = ctrl_p1;

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Bench for id_ex_pipeline_register: directed literal checks plus randomized traffic
// against a behavioural model. Define IDEX_BUBBLE_COUNT_EN to also cover BUBBLE_COUNT.
module tb_id_ex_pipeline_register;

  logic clk = 1'b0;
  logic rst_n;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  id_ex_pipeline_register_if #(.XLEN(32), .CTRL_W(16)) bus ();

  id_ex_pipeline_register dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  // Expected EX-side state, updated from the spec's per-edge rules.
  bit          m_known = 1'b0;
  bit          m_valid;
  logic [31:0] m_pc, m_d1, m_d2, m_imm, m_bub;
  logic [4:0]  m_a1, m_a2, m_rd;
  logic [15:0] m_ctrl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_known = 1'b1;
      m_valid = 0; m_pc = 0; m_d1 = 0; m_d2 = 0; m_imm = 0;
      m_a1 = 0; m_a2 = 0; m_rd = 0; m_ctrl = 0; m_bub = 0;
    end else if (bus.FLUSH) begin
      m_valid = 0; m_ctrl = 0; m_rd = 0; m_bub = m_bub + 1;
    end else if (bus.STALL) begin
      if (m_valid && bus.WB_WRITE_EN && bus.WB_REGISTER != 0) begin
        if (bus.WB_REGISTER == m_a1) m_d1 = bus.WB_DATA;
        if (bus.WB_REGISTER == m_a2) m_d2 = bus.WB_DATA;
      end
    end else begin
      m_valid = bus.ID_VALID;
      m_pc = bus.ID_PC; m_imm = bus.ID_IMM; m_rd = bus.ID_RD;
      m_a1 = bus.ID_ADDR1; m_a2 = bus.ID_ADDR2;
      m_d1 = (bus.OUT1_FORWARD_EN && bus.ID_ADDR1 != 0) ? bus.WB_DATA : bus.ID_DATA1;
      m_d2 = (bus.OUT2_FORWARD_EN && bus.ID_ADDR2 != 0) ? bus.WB_DATA : bus.ID_DATA2;
      m_ctrl = bus.ID_VALID ? bus.ID_CTRL : 16'h0;
      if (!bus.ID_VALID) m_bub = m_bub + 1;
    end
  end

  // Single compare process against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_known) begin
      chk("m_valid", 32'(bus.EX_VALID), 32'(m_valid));
      chk("m_ctrl", 32'(bus.EX_CTRL), 32'(m_ctrl));
      chk("m_rd", 32'(bus.EX_RD), 32'(m_rd));
      if (m_valid) begin
        chk("m_pc", bus.EX_PC, m_pc);
        chk("m_imm", bus.EX_IMM, m_imm);
        chk("m_a1", 32'(bus.EX_ADDR1), 32'(m_a1));
        chk("m_a2", 32'(bus.EX_ADDR2), 32'(m_a2));
        chk("m_d1", bus.EX_DATA1, m_d1);
        chk("m_d2", bus.EX_DATA2, m_d2);
      end
`ifdef IDEX_BUBBLE_COUNT_EN
      chk("m_bubble_count", bus.BUBBLE_COUNT, m_bub);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.STALL = 0; bus.FLUSH = 0; bus.ID_VALID = 0;
    bus.ID_PC = 0; bus.ID_DATA1 = 0; bus.ID_DATA2 = 0; bus.ID_IMM = 0;
    bus.ID_ADDR1 = 0; bus.ID_ADDR2 = 0; bus.ID_RD = 0; bus.ID_CTRL = 0;
    bus.OUT1_FORWARD_EN = 0; bus.OUT2_FORWARD_EN = 0;
    bus.WB_WRITE_EN = 0; bus.WB_REGISTER = 0; bus.WB_DATA = 0;
  endtask

  task automatic rand_id();
    bus.ID_VALID = 1'($urandom_range(0, 3) != 0);
    bus.ID_PC = $urandom; bus.ID_DATA1 = $urandom; bus.ID_DATA2 = $urandom;
    bus.ID_IMM = $urandom; bus.ID_CTRL = 16'($urandom);
    bus.ID_ADDR1 = 5'($urandom_range(0, 7)); bus.ID_ADDR2 = 5'($urandom_range(0, 7));
    bus.ID_RD = 5'($urandom);
  endtask

  initial begin
    idle();
    // Reset wins over stall with a valid instruction presented.
    rst_n = 0; bus.STALL = 1; bus.ID_VALID = 1; bus.ID_PC = 32'hDEAD0000;
    bus.ID_DATA1 = 32'h1234; bus.ID_CTRL = 16'hFFFF; bus.ID_RD = 5'd9;
    tick(); tick();
    chk("reset_valid", 32'(bus.EX_VALID), 32'h0);
    chk("reset_pc", bus.EX_PC, 32'h0);
    chk("reset_data1", bus.EX_DATA1, 32'h0);
    chk("reset_ctrl", 32'(bus.EX_CTRL), 32'h0);
    chk("reset_rd", 32'(bus.EX_RD), 32'h0);
    rst_n = 1; idle();

    // Forwarding of operand 1, then gated off for x0.
    bus.ID_VALID = 1; bus.ID_PC = 32'h100; bus.ID_ADDR1 = 5; bus.ID_DATA1 = 32'h11;
    bus.OUT1_FORWARD_EN = 1; bus.WB_DATA = 32'hABCD0001; bus.ID_CTRL = 16'h0081; bus.ID_RD = 3;
    tick();
    chk("fwd_data1", bus.EX_DATA1, 32'hABCD0001);
    chk("fwd_valid", 32'(bus.EX_VALID), 32'h1);
    bus.ID_ADDR1 = 0;
    tick();
    chk("fwd_x0_data1", bus.EX_DATA1, 32'h11);

    // Stall snoop on operand 2.
    idle();
    bus.ID_VALID = 1; bus.ID_PC = 32'h200; bus.ID_ADDR1 = 4; bus.ID_DATA1 = 32'h44;
    bus.ID_ADDR2 = 7; bus.ID_DATA2 = 32'h22; bus.ID_RD = 9; bus.ID_CTRL = 16'h0F01;
    bus.ID_IMM = 32'h123;
    tick();
    chk("load_data2", bus.EX_DATA2, 32'h22);
    rand_id(); bus.STALL = 1; bus.WB_WRITE_EN = 1; bus.WB_REGISTER = 7; bus.WB_DATA = 32'h99;
    tick();
    chk("snoop_data2", bus.EX_DATA2, 32'h99);
    chk("snoop_data1_held", bus.EX_DATA1, 32'h44);
    chk("snoop_pc_held", bus.EX_PC, 32'h200);
    chk("snoop_rd_held", 32'(bus.EX_RD), 32'h9);
    chk("snoop_ctrl_held", 32'(bus.EX_CTRL), 32'h0F01);
    chk("snoop_imm_held", bus.EX_IMM, 32'h123);
    bus.WB_REGISTER = 0; bus.WB_DATA = 32'h55;
    tick();
    chk("snoop_x0_ignored", bus.EX_DATA2, 32'h99);
    bus.WB_REGISTER = 7; bus.WB_DATA = 32'hA1;
    tick();
    bus.WB_DATA = 32'hB2;
    tick();
    chk("snoop_last_wins", bus.EX_DATA2, 32'hB2);

    // Flush together with stall gives a bubble; a held bubble is not snooped.
    bus.FLUSH = 1; bus.STALL = 1; bus.WB_WRITE_EN = 0;
    tick();
    chk("flush_valid", 32'(bus.EX_VALID), 32'h0);
    chk("flush_ctrl", 32'(bus.EX_CTRL), 32'h0);
    chk("flush_rd", 32'(bus.EX_RD), 32'h0);
    bus.FLUSH = 0; bus.WB_WRITE_EN = 1; bus.WB_REGISTER = 4; bus.WB_DATA = 32'h77;
    tick();
    chk("bubble_no_snoop", bus.EX_DATA1, 32'h44);
    idle();
    bus.ID_VALID = 1; bus.ID_PC = 32'h300; bus.ID_RD = 12; bus.ID_CTRL = 16'h0021;
    tick();
    chk("after_flush_valid", 32'(bus.EX_VALID), 32'h1);
    chk("after_flush_pc", bus.EX_PC, 32'h300);
    chk("after_flush_rd", 32'(bus.EX_RD), 32'd12);

    // Back-to-back loads.
    for (int i = 0; i < 5; i++) begin
      bus.ID_PC = 32'(i * 4);
      tick();
      chk("b2b_pc", bus.EX_PC, 32'(i * 4));
    end

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      rand_id();
      rst_n = ($urandom_range(0, 59) != 0);
      bus.STALL = ($urandom_range(0, 3) == 0);
      bus.FLUSH = ($urandom_range(0, 9) == 0);
      bus.OUT1_FORWARD_EN = 1'($urandom);
      bus.OUT2_FORWARD_EN = 1'($urandom);
      bus.WB_WRITE_EN = 1'($urandom);
      bus.WB_REGISTER = 5'($urandom_range(0, 7));
      bus.WB_DATA = $urandom;
      tick();
    end
    rst_n = 1;

`ifdef IDEX_BUBBLE_COUNT_EN
    // 3 flushes + 2 invalid loads interleaved with 4 stalls.
    idle(); rst_n = 0;
    tick();
    chk("bub_reset", bus.BUBBLE_COUNT, 32'd0);
    rst_n = 1;
    for (int i = 0; i < 9; i++) begin
      idle();
      case (i)
        0, 4, 8: bus.FLUSH = 1;
        2, 6:    bus.ID_VALID = 0;
        default: bus.STALL = 1;
      endcase
      tick();
    end
    chk("bub_count", bus.BUBBLE_COUNT, 32'd5);
`endif

    idle();
    tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
